// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and the RV32 datapath.
// The controller uses the master modport; the datapath (or a bench) uses slave.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       ImmSrc;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
           illegal, state, instret
  );

  modport slave (
    output op, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
           illegal, state, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencer for the shared-ALU / unified-memory multicycle RV32 datapath
// (lw, sw, R-type, addi-class, beq, jal) with memory-ready stalls, trap and instret.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_controller_if.master  ctrl
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // State-only part of the output decode, registered alongside the state.
  // fetch/beq mark states whose strobes are qualified by mem_ready/zero.
  typedef struct packed {
    logic       fetch;
    logic       beq;
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctl_t;

  function automatic ctl_t decode_ctl(state_e s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_ALUWB:    c.reg_write = 1'b1;
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_write  = 1'b1;
      end
      S_BEQ: begin
        c.beq       = 1'b1;
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
      end
      S_TRAP:     c.illegal = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  ctl_t             ctl_q;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  always_comb begin
    state_d = S_FETCH;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:   state_d = ctrl.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:  state_d = (ctrl.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = ctrl.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE: begin
        state_d = ctrl.mem_ready ? S_FETCH : S_MEMWRITE;
        retire  = ctrl.mem_ready;
      end
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_ALUWB, S_BEQ: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctl_q     <= decode_ctl(S_FETCH);
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= decode_ctl(state_d);
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  // Strobes are gated by reset directly so an in-flight access is killed immediately.
  assign ctrl.IRWrite   = ~reset & ctl_q.fetch & ctrl.mem_ready;
  assign ctrl.PCWrite   = ~reset & ((ctl_q.fetch & ctrl.mem_ready) | ctl_q.pc_write
                                    | (ctl_q.beq & ctrl.zero));
  assign ctrl.MemWrite  = ~reset & ctl_q.mem_write;
  assign ctrl.RegWrite  = ~reset & ctl_q.reg_write;
  assign ctrl.AdrSrc    = ctl_q.adr_src;
  assign ctrl.ResultSrc = ctl_q.result_src;
  assign ctrl.ALUSrcA   = ctl_q.alu_src_a;
  assign ctrl.ALUSrcB   = ctl_q.alu_src_b;
  assign ctrl.ALUOp     = ctl_q.alu_op;
  assign ctrl.illegal   = ctl_q.illegal;
  assign ctrl.state     = state_q;
  assign ctrl.instret   = instret_q;

  always_comb begin
    case (ctrl.op)
      OP_SW:   ctrl.ImmSrc = 2'b01;
      OP_BEQ:  ctrl.ImmSrc = 2'b10;
      OP_JAL:  ctrl.ImmSrc = 2'b11;
      default: ctrl.ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle compare against an
// instruction-level reference model, plus literal pins on key cycles.
module tb_multicycle_controller;
  localparam int CNT_W = 4;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic clk;
  logic reset;

  multicycle_controller_if #(.CNT_W(CNT_W)) bus ();
  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus.master)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    int               seq;
    logic [19:0]      v;
    logic [CNT_W-1:0] c;
  } exp_t;

  typedef struct {
    int               seq;
    string            name;
    logic [3:0]       st;
    logic             ill;
    logic [CNT_W-1:0] c;
  } pin_t;

  exp_t exp_q[$];
  pin_t pin_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   seq_n = 0;
  int   retired = 0;
  logic [6:0] cur_op = 7'd0;
  logic       cur_z = 1'b0;

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == SW)  return 2'b01;
    if (o == BEQ) return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Expected output word for a given architectural step, straight from the state rule table.
  function automatic logic [19:0] model(int st, logic mr, logic z, logic [6:0] o, logic rst);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, a, b, aop;
    {pcw, adr, mw, irw, rw, ill} = '0;
    {rs, a, b, aop} = '0;
    case (st)
      0:  begin b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  adr = 1'b1;
      4:  begin rs = 2'b01; rw = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; end
      6:  begin a = 2'b10; aop = 2'b10; end
      7:  rw = 1'b1;
      8:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      9:  begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      10: begin a = 2'b10; aop = 2'b01; pcw = z; end
      11: ill = 1'b1;
      default: ;
    endcase
    if (rst) {pcw, irw, rw, mw} = '0;
    return {4'(st), pcw, adr, mw, irw, rw, rs, a, b, aop, imm_of(o), ill};
  endfunction

  function automatic logic [CNT_W-1:0] cnt_exp();
    return CNT_W'(retired % (1 << CNT_W));
  endfunction

  task automatic cycle(int st, logic mr, bit ret);
    reset = 1'b0;
    bus.op = cur_op;
    bus.zero = cur_z;
    bus.mem_ready = mr;
    exp_q.push_back('{seq_n, model(st, mr, cur_z, cur_op, 1'b0), cnt_exp()});
    seq_n++;
    @(posedge clk); #1;
    if (ret) retired++;
  endtask

  task automatic rst_cycle(logic mr);
    reset = 1'b1;
    bus.op = cur_op;
    bus.zero = cur_z;
    bus.mem_ready = mr;
    retired = 0;
    exp_q.push_back('{seq_n, model(0, mr, cur_z, cur_op, 1'b1), cnt_exp()});
    seq_n++;
    @(posedge clk); #1;
  endtask

  task automatic pin(string name, logic [3:0] st, logic ill, logic [CNT_W-1:0] c);
    pin_q.push_back('{seq_n, name, st, ill, c});
  endtask

  task automatic instr(logic [6:0] o, logic z, int fw, int mw);
    cur_op = o;
    cur_z = z;
    for (int i = 0; i < fw; i++) cycle(0, 1'b0, 1'b0);
    cycle(0, 1'b1, 1'b0);
    cycle(1, 1'b1, 1'b0);
    case (o)
      LW: begin
        cycle(2, 1'b1, 1'b0);
        for (int i = 0; i < mw; i++) cycle(3, 1'b0, 1'b0);
        cycle(3, 1'b1, 1'b0);
        cycle(4, 1'b1, 1'b1);
      end
      SW: begin
        cycle(2, 1'b1, 1'b0);
        for (int i = 0; i < mw; i++) cycle(5, 1'b0, 1'b0);
        cycle(5, 1'b1, 1'b1);
      end
      RT:  begin cycle(6, 1'b1, 1'b0); cycle(7, 1'b1, 1'b1); end
      IT:  begin cycle(8, 1'b1, 1'b0); cycle(7, 1'b1, 1'b1); end
      JAL: begin cycle(9, 1'b1, 1'b0); cycle(7, 1'b1, 1'b1); end
      BEQ: cycle(10, 1'b1, 1'b1);
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    pin_t p;
    logic [19:0] act;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      act = {bus.state, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
             bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.illegal};
      n_vec++;
      if (act !== e.v || bus.instret !== e.c) begin
        n_err++;
        $display("FAIL cycle%0d outputs: got %05h instret %0d, expected %05h instret %0d",
                 e.seq, act, bus.instret, e.v, e.c);
      end
      while (pin_q.size() != 0 && pin_q[0].seq == e.seq) begin
        p = pin_q.pop_front();
        n_vec++;
        if (bus.state !== p.st || bus.illegal !== p.ill || bus.instret !== p.c) begin
          n_err++;
          $display("FAIL pin %s: got state %0d illegal %0b instret %0d, expected %0d %0b %0d",
                   p.name, bus.state, bus.illegal, bus.instret, p.st, p.ill, p.c);
        end
      end
    end
  end

  initial begin
    bus.op = 7'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    pin("reset", 4'd0, 1'b0, 4'd0);
    rst_cycle(1'b1);
    rst_cycle(1'b1);

    instr(LW, 1'b0, 0, 0);
    pin("lw_retired", 4'd0, 1'b0, 4'd1);
    instr(SW, 1'b0, 0, 0);
    instr(RT, 1'b1, 0, 0);
    instr(IT, 1'b0, 0, 0);
    instr(JAL, 1'b0, 0, 0);
    instr(BEQ, 1'b1, 0, 0);
    instr(BEQ, 1'b0, 0, 0);
    instr(RT, 1'b0, 3, 0);
    instr(SW, 1'b0, 0, 2);
    instr(LW, 1'b1, 1, 2);
    for (int i = 0; i < 6; i++) instr(RT, i[0], 0, 0);
    pin("wrap_to_zero", 4'd0, 1'b0, 4'd0);
    instr(RT, 1'b0, 0, 0);
    pin("after_wrap", 4'd0, 1'b0, 4'd1);

    cur_op = SW;
    cycle(0, 1'b1, 1'b0);
    cycle(1, 1'b1, 1'b0);
    cycle(2, 1'b1, 1'b0);
    cycle(5, 1'b0, 1'b0);
    pin("reset_mid_write", 4'd0, 1'b0, 4'd0);
    rst_cycle(1'b0);
    instr(BEQ, 1'b1, 0, 0);

    instr(BAD, 1'b0, 0, 0);
    pin("trap", 4'd11, 1'b1, 4'd1);
    for (int i = 0; i < 20; i++) begin
      cur_z = i[0];
      cycle(11, i[1], 1'b0);
    end
    pin("trap_reset", 4'd0, 1'b0, 4'd0);
    rst_cycle(1'b1);
    instr(RT, 1'b0, 0, 0);
    cycle(0, 1'b0, 1'b0);

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
